// File: rtl/cache_read_response_queue.sv
// Response FIFO between the cache access arbiter and the router injection port.
// Accepts up to four read results per cycle (N,S,E,W order) and drains one per cycle.
module cache_read_response_queue #(
    parameter int DATA_WIDTH     = 32,
    parameter int NET_ADDR_WIDTH = 4,
    parameter int DEPTH          = 8,
    parameter int PTR_WIDTH      = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  rd_valid,
    input  logic [4*NET_ADDR_WIDTH-1:0] rd_dest,
    input  logic [4*DATA_WIDTH-1:0]     rd_data,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [1:0]                  resp_port,
    output logic [NET_ADDR_WIDTH-1:0]   resp_dest,
    output logic [DATA_WIDTH-1:0]       resp_data,
    output logic [PTR_WIDTH:0]          fifo_count,
    output logic                        overflow,
    output logic [7:0]                  drop_count,
    input  logic                        clear_overflow
);
    localparam int ENTRY_W = 2 + NET_ADDR_WIDTH + DATA_WIDTH;
    localparam int CW      = PTR_WIDTH + 1;

    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_overflow;
    logic [7:0]           r_drop_count;

    logic [CW-1:0]        w_off [4];
    logic [CW-1:0]        w_total;
    logic [CW-1:0]        w_free;
    logic [CW-1:0]        w_accepted;
    logic [CW-1:0]        w_dropped;
    logic [3:0]           w_accept;
    logic                 w_fire;
    logic [ENTRY_W-1:0]   w_head;

    function automatic logic [CW-1:0] ext1(input logic b);
        return {{PTR_WIDTH{1'b0}}, b};
    endfunction

    // At most four results drop per cycle, so three bits of the drop amount suffice.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [CW-1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'b0, b[2:0]};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Slot offset of each port is the number of lower-index ports requesting.
    assign w_off[0] = '0;
    assign w_off[1] = ext1(rd_valid[0]);
    assign w_off[2] = ext1(rd_valid[0]) + ext1(rd_valid[1]);
    assign w_off[3] = ext1(rd_valid[0]) + ext1(rd_valid[1]) + ext1(rd_valid[2]);
    assign w_total  = w_off[3] + ext1(rd_valid[3]);

    // Room is measured before this cycle's pop; a simultaneous dequeue frees nothing.
    assign w_free     = CW'(DEPTH) - r_count;
    assign w_accepted = (w_total < w_free) ? w_total : w_free;
    assign w_dropped  = w_total - w_accepted;
    assign w_fire     = (r_count != '0) && resp_ready;

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < 4; i++) begin
            w_accept[i] = rd_valid[i] && (w_off[i] < w_free);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_accept[i]) begin
                r_mem[r_wr_ptr + w_off[i][PTR_WIDTH-1:0]] <=
                    {2'(i), rd_dest[i*NET_ADDR_WIDTH +: NET_ADDR_WIDTH],
                     rd_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_accepted[PTR_WIDTH-1:0];
            r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(w_fire);
            r_count  <= r_count + w_accepted - ext1(w_fire);
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count from it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_dropped != '0) begin
            r_overflow   <= 1'b1;
            r_drop_count <= sat_add(clear_overflow ? 8'd0 : r_drop_count, w_dropped);
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign resp_valid = (r_count != '0);
    assign resp_port  = resp_valid ? w_head[ENTRY_W-1 -: 2] : '0;
    assign resp_dest  = resp_valid ? w_head[DATA_WIDTH +: NET_ADDR_WIDTH] : '0;
    assign resp_data  = resp_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_cache_read_response_queue.sv
// Scoreboard bench for cache_read_response_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares every accepted response.
module tb_cache_read_response_queue;
    logic         clk;
    logic         reset;
    logic [3:0]   rd_valid;
    logic [15:0]  rd_dest;
    logic [127:0] rd_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_port;
    logic [3:0]   resp_dest;
    logic [31:0]  resp_data;
    logic [3:0]   fifo_count;
    logic         overflow;
    logic [7:0]   drop_count;
    logic         clear_overflow;

    logic [37:0]  sb [$];
    int           n_checks = 0;
    int           n_errors = 0;

    cache_read_response_queue dut (
        .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_dest(rd_dest),
        .rd_data(rd_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_port(resp_port), .resp_dest(resp_dest), .resp_data(resp_data),
        .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count),
        .clear_overflow(clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_errors++;
                n_checks++;
                $display("FAIL spurious_resp actual=%0h required=none", resp_data);
            end else begin
                check("resp", {26'd0, resp_port, resp_dest, resp_data}, {26'd0, sb.pop_front()});
            end
        end
    end

    // Port i carries data base+i and dest (base+i)[3:0]; acc marks ports expected to be kept.
    task automatic issue(input logic [3:0] v, input logic [3:0] acc, input logic [31:0] base,
                         input logic clr);
        for (int i = 0; i < 4; i++) begin
            rd_data[i*32 +: 32] = base + 32'(i);
            rd_dest[i*4 +: 4]   = 4'(base + 32'(i));
            if (acc[i]) sb.push_back({2'(i), 4'(base + 32'(i)), base + 32'(i)});
        end
        rd_valid       = v;
        clear_overflow = clr;
        @(posedge clk);
        #1;
        rd_valid       = '0;
        clear_overflow = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rd_valid = '0; rd_dest = '0; rd_data = '0;
        resp_ready = 1'b0; clear_overflow = 1'b0;
        #1 reset = 1'b0;
        #2;
        check("rst_valid", 64'(resp_valid), 0);
        check("rst_count", 64'(fifo_count), 0);
        check("rst_ovf", 64'(overflow), 0);
        check("rst_drops", 64'(drop_count), 0);
        check("rst_data", 64'(resp_data), 0);
        cycles(2);
        reset = 1'b1;
        cycles(1);

        // Four-wide burst drains in N,S,E,W order, one per cycle.
        resp_ready = 1'b1;
        issue(4'b1111, 4'b1111, 32'hA, 1'b0);
        check("lat_valid", 64'(resp_valid), 1);
        check("lat_data", 64'(resp_data), 64'hA);
        cycles(5);
        check("burst_count", 64'(fifo_count), 0);

        // Reset with five queued results.
        resp_ready = 1'b0;
        issue(4'b1111, 4'b1111, 32'h100, 1'b0);
        issue(4'b0001, 4'b0001, 32'h200, 1'b0);
        check("pre_rst_count", 64'(fifo_count), 5);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(resp_valid), 0);
        check("mid_rst_count", 64'(fifo_count), 0);
        check("mid_rst_data", 64'(resp_data), 0);
        check("mid_rst_port", 64'(resp_port), 0);
        sb.delete();
        cycles(1);
        reset = 1'b1;
        resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycles(1);
            check("post_rst_valid", 64'(resp_valid), 0);
        end

        // Head holds while resp_ready is low.
        resp_ready = 1'b0;
        issue(4'b0011, 4'b0011, 32'h300, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycles(1);
            check("hold_data", 64'(resp_data), 64'h300);
            check("hold_port", 64'(resp_port), 0);
            check("hold_count", 64'(fifo_count), 2);
        end
        resp_ready = 1'b1;
        cycles(3);
        check("hold_drain", 64'(fifo_count), 0);

        // Fill to 6, then 4'b1011 keeps N,S and drops W.
        resp_ready = 1'b0;
        issue(4'b1111, 4'b1111, 32'h400, 1'b0);
        issue(4'b0011, 4'b0011, 32'h410, 1'b0);
        check("six_count", 64'(fifo_count), 6);
        issue(4'b1011, 4'b0011, 32'h420, 1'b0);
        check("ovf_count", 64'(fifo_count), 8);
        check("ovf_flag", 64'(overflow), 1);
        check("ovf_drops", 64'(drop_count), 1);

        // Full with pop: the new request still drops.
        resp_ready = 1'b1;
        issue(4'b0001, 4'b0000, 32'h430, 1'b0);
        resp_ready = 1'b0;
        check("fullpop_count", 64'(fifo_count), 7);
        check("fullpop_drops", 64'(drop_count), 2);
        resp_ready = 1'b1;
        cycles(8);
        check("fullpop_drain", 64'(fifo_count), 0);

        // Move wr_ptr to 6, then a four-wide write straddles the wrap.
        issue(4'b1111, 4'b1111, 32'h500, 1'b0);
        cycles(5);
        resp_ready = 1'b0;
        issue(4'b1111, 4'b1111, 32'h600, 1'b0);
        check("wrap_count", 64'(fifo_count), 4);
        check("wrap_head", 64'(resp_data), 64'h600);
        resp_ready = 1'b1;
        cycles(5);
        check("wrap_drain", 64'(fifo_count), 0);

        // Clear, then 300 drops saturate at 255.
        resp_ready = 1'b0;
        issue(4'b0000, 4'b0000, 32'h0, 1'b1);
        check("clr_flag", 64'(overflow), 0);
        check("clr_drops", 64'(drop_count), 0);
        issue(4'b1111, 4'b1111, 32'h700, 1'b0);
        issue(4'b1111, 4'b1111, 32'h710, 1'b0);
        for (int k = 0; k < 75; k++) issue(4'b1111, 4'b0000, 32'h800, 1'b0);
        check("sat_drops", 64'(drop_count), 255);
        check("sat_flag", 64'(overflow), 1);
        issue(4'b0000, 4'b0000, 32'h0, 1'b1);
        check("sat_clr_drops", 64'(drop_count), 0);
        check("sat_clr_flag", 64'(overflow), 0);
        issue(4'b0011, 4'b0000, 32'h900, 1'b1);
        check("clr_drop_drops", 64'(drop_count), 2);
        check("clr_drop_flag", 64'(overflow), 1);
        resp_ready = 1'b1;
        cycles(9);
        check("final_count", 64'(fifo_count), 0);
        check("sb_empty", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
